// File: rtl/branch_flag_ctrl.sv
// branch_flag_ctrl: NZVC flag register plus ID-stage branch resolution.
// Latches flags from EX on flag-setting instructions, resolves B/CBZ/B.EQ/B.LT,
// stalls the front end on flag/operand hazards and pulses a one-cycle flush
// after every taken branch.
// Optional build macro: FLAG_FWD_EN -- forwards the EX flags straight into the
// B.EQ/B.LT condition so those branches never stall on a flag setter in EX.
module branch_flag_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_setflags,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_zero,
    input  logic             ex_ovf,
    input  logic             ex_cout,
    input  logic             id_br_valid,
    input  logic [1:0]       id_br_type,
    input  logic             id_rt_zero,
    input  logic             id_rt_hazard,
    output logic             stall,
    output logic             taken,
    output logic             flush,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] BR_B   = 2'b00;
    localparam logic [1:0] BR_CBZ = 2'b01;
    localparam logic [1:0] BR_EQ  = 2'b10;
    localparam logic [1:0] BR_LT  = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_cnt;

    logic       w_ex_wr;
    logic [3:0] w_ex_flags;
    logic [3:0] w_eff_flags;
    logic       w_hz;
    logic       w_cond;
    logic       w_stall;
    logic       w_taken;
    logic       w_unused_result;

    // Only the sign bit of the ALU result feeds the N flag.
    assign w_unused_result = ^ex_result[WIDTH-2:0];

    assign w_ex_wr    = ex_valid & ex_setflags;
    assign w_ex_flags = {ex_result[WIDTH-1], ex_zero, ex_ovf, ex_cout};

`ifdef FLAG_FWD_EN
    // Flag consumers see the in-flight EX flags, so they never wait.
    assign w_eff_flags = w_ex_wr ? w_ex_flags : r_flags;
`else
    assign w_eff_flags = r_flags;
`endif

    // Hazard: CBZ waits on its operand, flag branches on a flag setter in EX.
    always_comb begin
        w_hz = 1'b0;
        case (id_br_type)
            BR_CBZ:       w_hz = id_rt_hazard;
`ifdef FLAG_FWD_EN
            BR_EQ, BR_LT: w_hz = 1'b0;
`else
            BR_EQ, BR_LT: w_hz = w_ex_wr;
`endif
            default:      w_hz = 1'b0;
        endcase
    end

    // Branch condition on the effective flags {N,Z,V,C}.
    always_comb begin
        w_cond = 1'b0;
        case (id_br_type)
            BR_B:    w_cond = 1'b1;
            BR_CBZ:  w_cond = id_rt_zero;
            BR_EQ:   w_cond = w_eff_flags[2];
            BR_LT:   w_cond = w_eff_flags[3] ^ w_eff_flags[1];
            default: w_cond = 1'b0;
        endcase
    end

    // Next state and combinational stall/taken; FLUSH ignores the wrong-path ID slot.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_taken     = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (!id_br_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hz) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_taken     = w_cond;
                    w_state_nxt = w_cond ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Architectural flags: written by any real flag-setting EX instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_flags <= 4'b0000;
        else if (w_ex_wr) r_flags <= w_ex_flags;
    end

    // Saturating taken-branch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_cnt <= '0;
        else if (w_taken && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    // stall/taken are forced low while reset is held, even with a branch in ID.
    assign stall     = w_stall & ~reset;
    assign taken     = w_taken & ~reset;
    assign flush     = (r_state == S_FLUSH);
    assign flags_q   = r_flags;
    assign taken_cnt = r_cnt;

endmodule
